// File: rtl/sht10_pkg.sv
// sht10_pkg: shared types and constants for the SHT10 measurement scheduler.
package sht10_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_T,
    ST_WAIT_T,
    ST_START_RH,
    ST_WAIT_RH,
    ST_PERIOD,
    ST_RECOVER,
    ST_FAULT
  } state_t;

  localparam logic SEL_TEMP = 1'b0;
  localparam logic SEL_RH   = 1'b1;

  localparam int TEMP_W  = 14;
  localparam int RH_W    = 12;
  localparam int TMR_W   = 32;
  localparam int RETRY_W = 3;

endpackage

// File: rtl/sht10_sched_timer.sv
// sht10_sched_timer: loadable down-counter with zero flag. It is shared by the
// inter-measurement period and the conversion watchdog, which never overlap.
module sht10_sched_timer
  import sht10_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [TMR_W-1:0] r_count;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sht10_scheduler.sv
// sht10_scheduler: sequences temperature / RH conversions of the SHT10 core,
// retries with a connection reset on errors, and holds the latest results.
// Optional feature macro: SHT10_SCHED_TIMEOUT_EN enables the conversion
// watchdog (a hung conversion is treated as an error).
//
// state      | meaning
// IDLE       | waiting for run
// START_T    | issue temperature start, arm watchdog
// WAIT_T     | temperature conversion in progress
// START_RH   | issue RH start, arm watchdog
// WAIT_RH    | RH conversion in progress
// PERIOD     | idle gap before next temperature conversion
// RECOVER    | connection reset before retrying same measurement
// FAULT      | retries exhausted, wait for clear_fault
module sht10_scheduler
  import sht10_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 100_000_000,
  parameter int TIMEOUT_CYCLES = 40_000_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  input  logic              i_clear_fault,
  input  logic              i_meas_done,
  input  logic              i_meas_error,
  input  logic [15:0]       i_meas_data,
  output logic              o_meas_start,
  output logic              o_meas_sel,
  output logic              o_conn_reset,
  output logic [TEMP_W-1:0] o_temp_raw,
  output logic [RH_W-1:0]   o_rh_raw,
  output logic              o_temp_valid,
  output logic              o_rh_valid,
  output logic              o_busy,
  output logic              o_fault
);

  localparam logic [TMR_W-1:0]   L_PERIOD_LOAD  = TMR_W'(PERIOD_CYCLES - 1);
  localparam logic [TMR_W-1:0]   L_TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] L_MAX_RETRY    = RETRY_W'(MAX_RETRY);

  state_t              r_state;
  logic [RETRY_W-1:0]  r_retry_cnt;
  logic                r_meas_start;
  logic                r_meas_sel;
  logic                r_conn_reset;
  logic [TEMP_W-1:0]   r_temp_raw;
  logic [RH_W-1:0]     r_rh_raw;
  logic                r_temp_valid;
  logic                r_rh_valid;

  logic                w_in_wait;
  logic                w_timeout;
  logic                w_fail;
  logic                w_tmr_zero;
  logic                w_tmr_load;
  logic [TMR_W-1:0]    w_tmr_val;
  logic [RETRY_W-1:0]  w_retry_next;
  logic                w_unused_data;

  assign w_in_wait    = (r_state == ST_WAIT_T) || (r_state == ST_WAIT_RH);
  assign w_retry_next = r_retry_cnt + 3'd1;
  assign w_unused_data = ^i_meas_data[15:14];

`ifdef SHT10_SCHED_TIMEOUT_EN
  // A done arriving on the expiry cycle still counts as success.
  assign w_timeout = w_in_wait && w_tmr_zero && !i_meas_done;
`else
  assign w_timeout = 1'b0;
`endif

  // Error wins over a simultaneous done.
  assign w_fail = w_in_wait && (i_meas_error || w_timeout);

  // Watchdog armed on leaving START_x; period armed on a good RH result.
  assign w_tmr_load = (r_state == ST_START_T) || (r_state == ST_START_RH) ||
                      ((r_state == ST_WAIT_RH) && i_meas_done && !i_meas_error);
  assign w_tmr_val  = (r_state == ST_WAIT_RH) ? L_PERIOD_LOAD : L_TIMEOUT_LOAD;

  sht10_sched_timer u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  // Scheduler FSM with registered pulse and result outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_retry_cnt  <= '0;
      r_meas_start <= 1'b0;
      r_meas_sel   <= SEL_TEMP;
      r_conn_reset <= 1'b0;
      r_temp_raw   <= '0;
      r_rh_raw     <= '0;
      r_temp_valid <= 1'b0;
      r_rh_valid   <= 1'b0;
    end else begin
      r_meas_start <= 1'b0;
      r_conn_reset <= 1'b0;
      r_temp_valid <= 1'b0;
      r_rh_valid   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_run) begin
            r_state    <= ST_START_T;
            r_meas_sel <= SEL_TEMP;
          end
        end
        ST_START_T: begin
          r_meas_start <= 1'b1;
          r_state      <= ST_WAIT_T;
        end
        ST_START_RH: begin
          r_meas_start <= 1'b1;
          r_state      <= ST_WAIT_RH;
        end
        ST_WAIT_T: begin
          if (w_fail) begin
            r_retry_cnt <= w_retry_next;
            r_state     <= (w_retry_next < L_MAX_RETRY) ? ST_RECOVER : ST_FAULT;
          end else if (i_meas_done) begin
            r_retry_cnt  <= '0;
            r_temp_raw   <= i_meas_data[TEMP_W-1:0];
            r_temp_valid <= 1'b1;
            if (i_run) begin
              r_state    <= ST_START_RH;
              r_meas_sel <= SEL_RH;
            end else begin
              r_state    <= ST_IDLE;
            end
          end
        end
        ST_WAIT_RH: begin
          if (w_fail) begin
            r_retry_cnt <= w_retry_next;
            r_state     <= (w_retry_next < L_MAX_RETRY) ? ST_RECOVER : ST_FAULT;
          end else if (i_meas_done) begin
            r_retry_cnt <= '0;
            r_rh_raw    <= i_meas_data[RH_W-1:0];
            r_rh_valid  <= 1'b1;
            r_state     <= ST_PERIOD;
          end
        end
        ST_PERIOD: begin
          if (!i_run) begin
            r_state <= ST_IDLE;
          end else if (w_tmr_zero) begin
            r_state    <= ST_START_T;
            r_meas_sel <= SEL_TEMP;
          end
        end
        ST_RECOVER: begin
          r_conn_reset <= 1'b1;
          r_state      <= (r_meas_sel == SEL_RH) ? ST_START_RH : ST_START_T;
        end
        ST_FAULT: begin
          if (i_clear_fault) begin
            r_state     <= ST_IDLE;
            r_retry_cnt <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_meas_start = r_meas_start;
  assign o_meas_sel   = r_meas_sel;
  assign o_conn_reset = r_conn_reset;
  assign o_temp_raw   = r_temp_raw;
  assign o_rh_raw     = r_rh_raw;
  assign o_temp_valid = r_temp_valid;
  assign o_rh_valid   = r_rh_valid;
  assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_FAULT);
  assign o_fault      = (r_state == ST_FAULT);

endmodule

// File: tb/tb_sht10_scheduler.sv
// tb_sht10_scheduler: randomized bench for sht10_scheduler with a small
// behavioural core responder and result/event model.
module tb_sht10_scheduler;

  localparam int P = 100;
  localparam int T = 50;
  localparam int R = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        clr = 1'b0;
  logic        done = 1'b0;
  logic        err = 1'b0;
  logic [15:0] data = 16'h0;

  logic        o_meas_start, o_meas_sel, o_conn_reset;
  logic [13:0] o_temp_raw;
  logic [11:0] o_rh_raw;
  logic        o_temp_valid, o_rh_valid, o_busy, o_fault;

  always #5 clk = ~clk;

  sht10_scheduler #(
    .PERIOD_CYCLES  (P),
    .TIMEOUT_CYCLES (T),
    .MAX_RETRY      (R)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_run         (run),
    .i_clear_fault (clr),
    .i_meas_done   (done),
    .i_meas_error  (err),
    .i_meas_data   (data),
    .o_meas_start  (o_meas_start),
    .o_meas_sel    (o_meas_sel),
    .o_conn_reset  (o_conn_reset),
    .o_temp_raw    (o_temp_raw),
    .o_rh_raw      (o_rh_raw),
    .o_temp_valid  (o_temp_valid),
    .o_rh_valid    (o_rh_valid),
    .o_busy        (o_busy),
    .o_fault       (o_fault)
  );

  int checks = 0;
  int errors = 0;

  // event counters observed from the DUT pins
  int n_start = 0;
  int n_conn  = 0;
  int n_tv    = 0;
  int n_rv    = 0;

  // reference model: last good results and expected connection resets
  logic [13:0] m_temp = '0;
  logic [11:0] m_rh   = '0;
  int          m_conn = 0;

  always @(negedge clk) begin
    if (o_meas_start) n_start++;
    if (o_conn_reset) n_conn++;
    if (o_temp_valid) n_tv++;
    if (o_rh_valid)   n_rv++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // which: 0 = meas_start, 1 = conn_reset; n = negedges until seen, -1 if never
  task automatic wait_pulse(input int which, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((which == 0 && o_meas_start === 1'b1) || (which == 1 && o_conn_reset === 1'b1)) begin
        n = i;
        break;
      end
    end
  endtask

  // core responder: one-cycle pulse after 'delay' cycles, returns on the
  // negedge following the edge that sampled it
  task automatic respond(input int delay, input logic d_done, input logic d_err, input logic [15:0] d);
    repeat (delay) @(negedge clk);
    done = d_done;
    err  = d_err;
    data = d;
    @(negedge clk);
    done = 1'b0;
    err  = 1'b0;
  endtask

  // mode 0: clean; 1: one error then done; 2: done+error together then done.
  // Called on the negedge where meas_start was seen.
  task automatic do_meas(input logic is_rh, input logic [15:0] d, input int mode);
    int n;
    int v0;
    chk("sel_at_start", 32'(o_meas_sel), 32'(is_rh));
    if (mode != 0) begin
      v0 = n_tv + n_rv;
      respond(int'($urandom_range(0, 10)), (mode == 2), 1'b1, 16'($urandom));
      wait_pulse(1, 5, n);
      chk("conn_reset_lat", 32'(n), 32'd1);
      m_conn++;
      wait_pulse(0, 3, n);
      chk("restart_lat", 32'(n), 32'd1);
      chk("sel_retry", 32'(o_meas_sel), 32'(is_rh));
      chk("fault_after_1err", 32'(o_fault), 32'd0);
      #1;
      chk("no_valid_on_err", 32'(n_tv + n_rv), 32'(v0));
      chk("temp_held_on_err", 32'(o_temp_raw), 32'(m_temp));
      chk("rh_held_on_err", 32'(o_rh_raw), 32'(m_rh));
    end
    respond(int'($urandom_range(0, 20)), 1'b1, 1'b0, d);
    if (is_rh) begin
      m_rh = d[11:0];
      chk("rh_valid", 32'(o_rh_valid), 32'd1);
      chk("rh_raw", 32'(o_rh_raw), 32'(m_rh));
    end else begin
      m_temp = d[13:0];
      chk("temp_valid", 32'(o_temp_valid), 32'd1);
      chk("temp_raw", 32'(o_temp_raw), 32'(m_temp));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, 32'(o_meas_start), 32'd0);
    chk({tag, "_sel"},   32'(o_meas_sel),   32'd0);
    chk({tag, "_conn"},  32'(o_conn_reset), 32'd0);
    chk({tag, "_traw"},  32'(o_temp_raw),   32'd0);
    chk({tag, "_rraw"},  32'(o_rh_raw),     32'd0);
    chk({tag, "_tv"},    32'(o_temp_valid), 32'd0);
    chk({tag, "_rv"},    32'(o_rh_valid),   32'd0);
    chk({tag, "_busy"},  32'(o_busy),       32'd0);
    chk({tag, "_fault"}, 32'(o_fault),      32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int n;
    int s0;
    int c0;
    logic [15:0] d;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // directed first cycle: temperature 0x1A2B then RH 0x0456
    @(negedge clk);
    run = 1'b1;
    wait_pulse(0, 10, n);
    chk("run_to_start", 32'(n), 32'd2);
    do_meas(1'b0, 16'h1A2B, 0);
    wait_pulse(0, 5, n);
    chk("rh_start_after_tv", 32'(n), 32'd1);
    do_meas(1'b1, 16'h0456, 0);
    wait_pulse(0, P + 20, n);
    chk("period_gap", 32'(n >= P && n <= P + 3), 32'd1);
    #1;
    chk("tv_count", 32'(n_tv), 32'd1);
    chk("rv_count", 32'(n_rv), 32'd1);

    // randomized cycles with occasional retries
    for (int it = 0; it < 6; it++) begin
      do_meas(1'b0, 16'($urandom), int'($urandom_range(0, 2)));
      wait_pulse(0, 5, n);
      chk("rh_follow", 32'(n), 32'd1);
      do_meas(1'b1, 16'($urandom), int'($urandom_range(0, 2)));
      if (it < 5) begin
        wait_pulse(0, P + 20, n);
        chk("period_gap", 32'(n >= P && n <= P + 3), 32'd1);
      end
    end
    run = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("conn_count", 32'(n_conn), 32'(m_conn));
    chk("temp_final", 32'(o_temp_raw), 32'(m_temp));
    chk("rh_final", 32'(o_rh_raw), 32'(m_rh));
    s0 = n_start;
    repeat (30) @(negedge clk);
    #1;
    chk("idle_no_start", 32'(n_start), 32'(s0));

    // two consecutive errors -> FAULT
    @(negedge clk);
    run = 1'b1;
    wait_pulse(0, 10, n);
    chk("fault_run_start", 32'(n), 32'd2);
    respond(3, 1'b0, 1'b1, 16'h0);
    wait_pulse(1, 5, n);
    chk("fault_conn1", 32'(n), 32'd1);
    m_conn++;
    wait_pulse(0, 3, n);
    chk("fault_restart", 32'(n), 32'd1);
    respond(2, 1'b0, 1'b1, 16'h0);
    #1;
    chk("fault_set", 32'(o_fault), 32'd1);
    chk("fault_busy", 32'(o_busy), 32'd0);
    s0 = n_start;
    repeat (20) @(negedge clk);
    #1;
    chk("fault_no_start", 32'(n_start), 32'(s0));
    chk("fault_conn_total", 32'(n_conn), 32'(m_conn));
    chk("fault_held", 32'(o_temp_raw), 32'(m_temp));
    run = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clear_fault", 32'(o_fault), 32'd0);
    chk("clear_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    run = 1'b1;
    wait_pulse(0, 10, n);
    chk("restart_after_clear", 32'(n), 32'd2);
    do_meas(1'b0, 16'($urandom), 2);
    wait_pulse(0, 5, n);
    chk("rh_after_clear", 32'(n), 32'd1);
    do_meas(1'b1, 16'($urandom), 0);
    run = 1'b0;
    repeat (2) @(negedge clk);

`ifdef SHT10_SCHED_TIMEOUT_EN
    // silent core: watchdog fires, then second expiry faults
    run = 1'b1;
    wait_pulse(0, 10, n);
    chk("to_start", 32'(n), 32'd2);
    wait_pulse(1, T + 20, n);
    chk("to_conn_lat", 32'(n >= T && n <= T + 2), 32'd1);
    m_conn++;
    wait_pulse(0, 3, n);
    chk("to_restart", 32'(n), 32'd1);
    repeat (T + 5) @(negedge clk);
    #1;
    chk("to_fault", 32'(o_fault), 32'd1);
    chk("to_conn_total", 32'(n_conn), 32'(m_conn));
    run = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("to_cleared", 32'(o_fault), 32'd0);
`else
    // silent core without watchdog: stays waiting
    run = 1'b1;
    wait_pulse(0, 10, n);
    chk("nto_start", 32'(n), 32'd2);
    c0 = n_conn;
    repeat (1000) @(negedge clk);
    #1;
    chk("nto_busy", 32'(o_busy), 32'd1);
    chk("nto_no_conn", 32'(n_conn), 32'(c0));
    chk("nto_no_fault", 32'(o_fault), 32'd0);
    run = 1'b0;
    respond(1, 1'b1, 1'b0, 16'h2345);
    m_temp = 14'h2345;
    chk("nto_done", 32'(o_temp_raw), 32'(m_temp));
`endif

    // run dropped during WAIT_T: result lands, no RH
    @(negedge clk);
    run = 1'b1;
    wait_pulse(0, 10, n);
    chk("drop_start", 32'(n), 32'd2);
    run = 1'b0;
    d = 16'($urandom);
    respond(5, 1'b1, 1'b0, d);
    m_temp = d[13:0];
    chk("drop_tv", 32'(o_temp_valid), 32'd1);
    chk("drop_traw", 32'(o_temp_raw), 32'(m_temp));
    #1;
    s0 = n_start;
    repeat (20) @(negedge clk);
    #1;
    chk("drop_no_rh", 32'(n_start), 32'(s0));
    chk("drop_idle", 32'(o_busy), 32'd0);

    // reset during WAIT_RH
    @(negedge clk);
    run = 1'b1;
    wait_pulse(0, 10, n);
    do_meas(1'b0, 16'($urandom), 0);
    wait_pulse(0, 5, n);
    chk("rst_rh_start", 32'(n), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    #1;
    s0 = n_start;
    c0 = n_conn;
    repeat (5) @(negedge clk);
    #1;
    chk("midrst_no_start", 32'(n_start), 32'(s0));
    chk("midrst_no_conn", 32'(n_conn), 32'(c0));
    run = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sht10_scheduler.md
# sht10_scheduler

Measurement scheduler for the SHT10 sensor interface core. Sequences the core: alternates temperature and relative-humidity conversions at a fixed period, issues connection resets and retries on communication errors or hung conversions, and holds the latest raw results with valid strobes for the display and readout logic. Sits between the board-level run/clear controls and the core's start/select/reset_conn/com_error signals.

## Interface
- PERIOD_CYCLES, 100_000_000: cycles from end of RH conversion to next temperature start (1 s at 100 MHz); ≥ 2.
- TIMEOUT_CYCLES, 40_000_000: maximum cycles from meas_start to meas_done/meas_error (400 ms); ≥ 2.
- MAX_RETRY, 3: consecutive failed attempts tolerated per measurement before fault; 1–7.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; high = continuous scheduling.
- clear_fault  in  1  pulse; leaves FAULT.
- meas_done  in  1  core pulse: conversion and readout complete, meas_data valid this cycle.
- meas_error  in  1  core pulse: com_error (missing ACK/CRC failure).
- meas_data  in  16  raw result from core.
- meas_start  out  1  one-cycle start pulse to core.
- meas_sel  out  1  0 = temperature, 1 = RH; stable from meas_start until done/error.
- conn_reset  out  1  one-cycle connection-reset pulse to core.
- temp_raw  out  14  last good temperature, meas_data[13:0].
- rh_raw  out  12  last good RH, meas_data[11:0].
- temp_valid, rh_valid  out  1 each  one-cycle strobe on update.
- busy  out  1  high in every state except IDLE and FAULT.
- fault  out  1  high in FAULT.

## Operation
- States: IDLE, START_T, WAIT_T, START_RH, WAIT_RH, PERIOD, RECOVER, FAULT.
- IDLE: run=1 → START_T.
- START_T/START_RH: meas_start=1 for one cycle, meas_sel set, timeout counter loaded → WAIT_T/WAIT_RH.
- WAIT_x, meas_done: latch result, strobe valid, clear retry count. WAIT_T → START_RH if run=1, else IDLE. WAIT_RH → PERIOD (counter loaded PERIOD_CYCLES-1).
- WAIT_x, meas_error or timeout expiry: retry_cnt+1. If new count < MAX_RETRY → RECOVER, else → FAULT.
- RECOVER: conn_reset=1 for one cycle, then re-enter START of the same measurement (meas_sel preserved).
- PERIOD: counter reaches 0 → START_T if run=1, else IDLE. run=0 earlier → IDLE immediately.
- FAULT: all pulses low, results held; clear_fault → IDLE, retry count cleared.
- meas_done and meas_error same cycle: error wins, data not latched.
- meas_done/meas_error outside WAIT_x: ignored.
- run=0 during WAIT_x: current conversion finishes (or fails) before IDLE; RH is not started.

## Timing
- Reset values: all outputs 0, temp_raw=0, rh_raw=0, state IDLE, counters 0.
- run rising in IDLE → meas_start at cycle +2 (IDLE→START_T registered).
- meas_done in WAIT_x → valid strobe and updated data on next edge; RH start follows 2 cycles after temperature meas_done.
- Timeout fires when TIMEOUT_CYCLES cycles elapse in WAIT_x without done/error.
- Error → conn_reset one cycle later → meas_start one cycle after that.
- Reset asserted mid-operation: immediate return to reset values; no pulse emitted.

## Configuration
- SHT10_SCHED_TIMEOUT_EN defined: watchdog counter present; timeout treated as an error.
- Not defined: no watchdog; WAIT_x exits only on meas_done/meas_error; TIMEOUT_CYCLES unused.

## Structure
- sht10_pkg: state enum, SEL_TEMP/SEL_RH constants, result widths (14, 12).
- Sub-module sht10_sched_timer: loadable down-counter with zero flag, shared by period and timeout (states mutually exclusive).

## Test plan
Bench parameters: PERIOD_CYCLES=100, TIMEOUT_CYCLES=50, MAX_RETRY=2.
- run=1, core returns done with 0x1A2B then 0x0456 → temp_raw=0x1A2B, rh_raw=0x456, one strobe each, next meas_start 100+ cycles after rh_valid.
- First temp attempt meas_error, second done → one conn_reset, second meas_start with meas_sel=0, fault=0.
- Two consecutive meas_error → fault=1, busy=0; clear_fault → IDLE; run=1 restarts at START_T.
- With macro, no core response → conn_reset after 50 cycles; again → fault. Without macro: still in WAIT_T after 1000 cycles.
- Done and error same cycle → no temp_valid, retry path taken.
- run dropped in WAIT_T, done arrives → temp_valid, no RH start, IDLE; reset mid-WAIT_RH → all outputs 0.
